// File: rtl/mem_stage_sram_pkg.sv
// Shared types and constants for the memory stage and its SRAM controller.
// Holds the wait-state FSM encoding and the data-memory map constants.
// No logic; imported by every design file of the memory stage.
package mem_stage_sram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_DONE = 2'd3
   } mem_state_t;

   localparam int DATA_BASE_ADDR = 1024;
   localparam int SRAM_DATA_W    = 16;

endpackage

// File: rtl/mem_stage_sram_controller.sv
// Word load/store engine on a 16-bit SRAM: low half then high half, each held WAIT_CYCLES+1 cycles.
// Latency: ready rises 2*WAIT_CYCLES+3 cycles after a request appears in IDLE; non-memory ops pass at once.
// Backpressure: ready=0 freezes upstream, so request inputs are assumed stable for the whole access.
module sram_controller
   import mem_stage_sram_pkg::*;
#(
   parameter int n           = 32,
   parameter int WAIT_CYCLES = 1,
   parameter int BASE_ADDR   = DATA_BASE_ADDR,
   parameter int SRAM_AW     = 18
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rd_req,
   input  logic                   wr_req,
   input  logic [n-1:0]           addr,
   input  logic [n-1:0]           wr_data,
   output logic                   ready,
   output logic [n-1:0]           rd_data,
   output logic [SRAM_AW-1:0]     sram_addr,
   output logic [SRAM_DATA_W-1:0] sram_dq_out,
   input  logic [SRAM_DATA_W-1:0] sram_dq_in,
   output logic                   sram_dq_oe,
   output logic                   sram_we_n
);

   localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(WAIT_CYCLES);
   localparam logic [CW-1:0] CNT_PENULT = CW'(WAIT_CYCLES - 1);

   mem_state_t             state;
   logic [CW-1:0]          cnt;
   logic [SRAM_DATA_W-1:0] lo_reg;

   logic                   req;
   logic                   is_wr;
   logic [n-1:0]           off;
   logic [SRAM_AW-2:0]     widx;
   logic [SRAM_AW-1:0]     lo_addr;
   logic [SRAM_AW-1:0]     hi_addr;

   // Write wins when both enables are set; byte offset bits are dropped (aligned words only).
   assign req     = rd_req | wr_req;
   assign is_wr   = wr_req;
   assign off     = addr - n'(BASE_ADDR);
   assign widx    = (SRAM_AW-1)'(off >> 2);
   assign lo_addr = {widx, 1'b0};
   assign hi_addr = {widx, 1'b1};

   // In IDLE the stage only stalls if a memory op is waiting; DONE releases the pipeline for one cycle.
   assign ready = (state == ST_IDLE) ? ~req : (state == ST_DONE);

   // Wait-state FSM; bus outputs are registered and set up on the edge that enters each phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         lo_reg      <= '0;
         rd_data     <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  state      <= ST_LO;
                  cnt        <= '0;
                  sram_addr  <= lo_addr;
                  sram_dq_oe <= is_wr;
                  sram_we_n  <= ~is_wr;
                  if (is_wr) sram_dq_out <= wr_data[SRAM_DATA_W-1:0];
               end
            end
            ST_LO: begin
               if (cnt == CNT_LAST) begin
                  state      <= ST_HI;
                  cnt        <= '0;
                  sram_addr  <= hi_addr;
                  sram_dq_oe <= is_wr;
                  sram_we_n  <= ~is_wr;
                  if (is_wr) sram_dq_out <= wr_data[2*SRAM_DATA_W-1:SRAM_DATA_W];
                  else       lo_reg      <= sram_dq_in;
               end else begin
                  cnt <= cnt + 1'b1;
                  // last cycle of the half is a hold cycle with the strobe released
                  if (cnt == CNT_PENULT) sram_we_n <= 1'b1;
               end
            end
            ST_HI: begin
               if (cnt == CNT_LAST) begin
                  state      <= ST_DONE;
                  cnt        <= '0;
                  sram_dq_oe <= 1'b0;
                  sram_we_n  <= 1'b1;
                  if (!is_wr) rd_data <= n'({sram_dq_in, lo_reg});
               end else begin
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_PENULT) sram_we_n <= 1'b1;
               end
            end
            ST_DONE: begin
               // pipeline advances on this edge, so the next instruction is evaluated fresh in IDLE
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/mem_stage_sram.sv
// Memory pipeline stage: SRAM-backed word loads/stores plus combinational passthrough to MEM/WB.
// Latency: memory ops 2*WAIT_CYCLES+3 cycles to ready; non-memory ops complete in the same cycle.
// Backpressure: ready=0 freezes all earlier stages; passthroughs stay stable because EXE/MEM is frozen.
module mem_stage_sram
   import mem_stage_sram_pkg::*;
#(
   parameter int n           = 32,
   parameter int WAIT_CYCLES = 1,
   parameter int BASE_ADDR   = DATA_BASE_ADDR,
   parameter int SRAM_AW     = 18
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   WB_EN_in,
   input  logic                   MEM_R_EN_in,
   input  logic                   MEM_W_EN_in,
   input  logic [n-1:0]           ALU_res_in,
   input  logic [n-1:0]           Val_Rm_in,
   input  logic [3:0]             Dest_in,
   output logic                   WB_EN_out,
   output logic                   MEM_R_EN_out,
   output logic [3:0]             Dest_out,
   output logic [n-1:0]           ALU_res_out,
   output logic [n-1:0]           mem_data,
   output logic                   ready,
   output logic [SRAM_AW-1:0]     sram_addr,
   output logic [SRAM_DATA_W-1:0] sram_dq_out,
   input  logic [SRAM_DATA_W-1:0] sram_dq_in,
   output logic                   sram_dq_oe,
   output logic                   sram_we_n
);

   assign WB_EN_out    = WB_EN_in;
   assign MEM_R_EN_out = MEM_R_EN_in;
   assign Dest_out     = Dest_in;
   assign ALU_res_out  = ALU_res_in;

   sram_controller #(
      .n          (n),
      .WAIT_CYCLES(WAIT_CYCLES),
      .BASE_ADDR  (BASE_ADDR),
      .SRAM_AW    (SRAM_AW)
   ) u_ctrl (
      .clk        (clk),
      .rst        (rst),
      .rd_req     (MEM_R_EN_in),
      .wr_req     (MEM_W_EN_in),
      .addr       (ALU_res_in),
      .wr_data    (Val_Rm_in),
      .ready      (ready),
      .rd_data    (mem_data),
      .sram_addr  (sram_addr),
      .sram_dq_out(sram_dq_out),
      .sram_dq_in (sram_dq_in),
      .sram_dq_oe (sram_dq_oe),
      .sram_we_n  (sram_we_n)
   );

endmodule

// File: tb/tb_mem_stage_sram.sv
`timescale 1ns/1ps

// Behavioural async SRAM: read data is only valid once the address has been held WAIT_CYCLES+1 cycles.
module sram_model #(
   parameter int WAIT_CYCLES = 1,
   parameter int AW          = 18
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   dq_out,
   input  logic          oe,
   input  logic          we_n,
   output logic [15:0]   dq_in
);
   logic [15:0]   mem [0:(1<<AW)-1];
   logic [AW-1:0] last_addr;
   int            held;
   int            age;
   int            bad_wr;

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
      last_addr = '0;
      held      = 0;
      bad_wr    = 0;
   end

   assign age   = (addr == last_addr) ? held + 1 : 1;
   assign dq_in = (age > WAIT_CYCLES) ? mem[addr] : 16'hA5A5;

   always @(posedge clk) begin
      if (!we_n) mem[addr] <= dq_out;
      if (!we_n && !oe) bad_wr <= bad_wr + 1;
      held      <= (age < 1000) ? age : held;
      last_addr <= addr;
   end
endmodule

module tb_mem_stage_sram;
   localparam int W0 = 1;
   localparam int W1 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        wb_in  [2];
   logic        r_in   [2];
   logic        w_in   [2];
   logic [31:0] alu_in [2];
   logic [31:0] val_in [2];
   logic [3:0]  dest_in[2];
   logic        wb_o   [2];
   logic        r_o    [2];
   logic [3:0]  dest_o [2];
   logic [31:0] alu_o  [2];
   logic [31:0] mdat_o [2];
   logic        rdy_o  [2];
   logic [17:0] addr_o [2];
   logic [15:0] dqo    [2];
   logic [15:0] dqi    [2];
   logic        oe_o   [2];
   logic        wen_o  [2];

   mem_stage_sram #(.n(32), .WAIT_CYCLES(W0), .BASE_ADDR(1024), .SRAM_AW(18)) dut0 (
      .clk(clk), .rst(rst), .WB_EN_in(wb_in[0]), .MEM_R_EN_in(r_in[0]), .MEM_W_EN_in(w_in[0]),
      .ALU_res_in(alu_in[0]), .Val_Rm_in(val_in[0]), .Dest_in(dest_in[0]),
      .WB_EN_out(wb_o[0]), .MEM_R_EN_out(r_o[0]), .Dest_out(dest_o[0]), .ALU_res_out(alu_o[0]),
      .mem_data(mdat_o[0]), .ready(rdy_o[0]), .sram_addr(addr_o[0]), .sram_dq_out(dqo[0]),
      .sram_dq_in(dqi[0]), .sram_dq_oe(oe_o[0]), .sram_we_n(wen_o[0]));

   mem_stage_sram #(.n(32), .WAIT_CYCLES(W1), .BASE_ADDR(1024), .SRAM_AW(18)) dut1 (
      .clk(clk), .rst(rst), .WB_EN_in(wb_in[1]), .MEM_R_EN_in(r_in[1]), .MEM_W_EN_in(w_in[1]),
      .ALU_res_in(alu_in[1]), .Val_Rm_in(val_in[1]), .Dest_in(dest_in[1]),
      .WB_EN_out(wb_o[1]), .MEM_R_EN_out(r_o[1]), .Dest_out(dest_o[1]), .ALU_res_out(alu_o[1]),
      .mem_data(mdat_o[1]), .ready(rdy_o[1]), .sram_addr(addr_o[1]), .sram_dq_out(dqo[1]),
      .sram_dq_in(dqi[1]), .sram_dq_oe(oe_o[1]), .sram_we_n(wen_o[1]));

   sram_model #(.WAIT_CYCLES(W0)) m0 (.clk(clk), .addr(addr_o[0]), .dq_out(dqo[0]), .oe(oe_o[0]),
                                      .we_n(wen_o[0]), .dq_in(dqi[0]));
   sram_model #(.WAIT_CYCLES(W1)) m1 (.clk(clk), .addr(addr_o[1]), .dq_out(dqo[1]), .oe(oe_o[1]),
                                      .we_n(wen_o[1]), .dq_in(dqi[1]));

   int checks   = 0;
   int failures = 0;

   // Reference: whole 32-bit words keyed by (instance, word index); last completed load per instance.
   logic [31:0] ref_mem [int];
   logic [31:0] last_load [2];

   typedef struct {
      int          sel;
      bit          r;
      bit          w;
      logic [31:0] alu;
      logic [31:0] val;
      logic [3:0]  dest;
      bit          wb;
      int          lat;
      logic [31:0] data;
   } vec_t;
   vec_t tbl[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int wcy(input int sel);
      return (sel == 0) ? W0 : W1;
   endfunction

   // Word index from the memory map: (ALU - base) / 4, modulo the 2^17 words the SRAM holds.
   function automatic logic [16:0] widx(input logic [31:0] alu);
      logic [31:0] off;
      off = alu - 32'd1024;
      return 17'(off / 4);
   endfunction

   function automatic int key(input int sel, input logic [16:0] wi);
      return sel * (1 << 20) + int'(wi);
   endfunction

   function automatic logic [31:0] ref_read(input int sel, input logic [16:0] wi);
      return ref_mem.exists(key(sel, wi)) ? ref_mem[key(sel, wi)] : 32'h0;
   endfunction

   function automatic logic [15:0] sram_rd(input int sel, input logic [17:0] a);
      return (sel == 0) ? m0.mem[a] : m1.mem[a];
   endfunction

   // Present one instruction at posedge+1, follow it to the ready cycle, then let the pipeline advance.
   task automatic do_op(input int sel, input bit r, input bit w, input logic [31:0] alu,
                        input logic [31:0] val, input logic [3:0] dest, input bit wb,
                        input int exp_lat, input logic [31:0] exp_data);
      int lat, welow, lo_cnt, hi_cnt;
      logic [16:0] wi;
      logic [17:0] lo_a, hi_a;
      wi   = widx(alu);
      lo_a = {wi, 1'b0};
      hi_a = {wi, 1'b1};
      wb_in[sel] = wb; r_in[sel] = r; w_in[sel] = w;
      alu_in[sel] = alu; val_in[sel] = val; dest_in[sel] = dest;
      lat = -1; welow = 0; lo_cnt = 0; hi_cnt = 0;
      @(negedge clk);
      chk("pass_wb", {63'd0, wb_o[sel]}, {63'd0, wb});
      chk("pass_mem_r", {63'd0, r_o[sel]}, {63'd0, r});
      chk("pass_dest", {60'd0, dest_o[sel]}, {60'd0, dest});
      chk("pass_alu", {32'd0, alu_o[sel]}, {32'd0, alu});
      chk("mem_data_held", {32'd0, mdat_o[sel]}, {32'd0, last_load[sel]});
      for (int c = 0; c < 40; c++) begin
         if (c > 0) @(negedge clk);
         if (!wen_o[sel]) welow++;
         if (c > 0 && addr_o[sel] == lo_a) lo_cnt++;
         if (c > 0 && addr_o[sel] == hi_a) hi_cnt++;
         if (rdy_o[sel]) begin
            lat = c;
            break;
         end
      end
      chk("ready_latency", 64'(lat), 64'(exp_lat));
      chk("we_n_low_cycles", 64'(welow), 64'(w ? 2 * wcy(sel) : 0));
      if (r || w) begin
         chk("lo_addr_cycles", 64'(lo_cnt), 64'(wcy(sel) + 1));
         chk("hi_addr_cycles", 64'(hi_cnt), 64'(wcy(sel) + 2));
      end
      chk("mem_data_done", {32'd0, mdat_o[sel]}, {32'd0, exp_data});
      if (w) begin
         ref_mem[key(sel, wi)] = val;
         chk("sram_lo_half", {48'd0, sram_rd(sel, lo_a)}, {48'd0, val[15:0]});
         chk("sram_hi_half", {48'd0, sram_rd(sel, hi_a)}, {48'd0, val[31:16]});
      end
      last_load[sel] = exp_data;
      @(posedge clk);
      #1;
      r_in[sel] = 1'b0;
      w_in[sel] = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{0, 1'b0, 1'b0, 32'h0000_1234, 32'h0,         4'd5,  1'b1, 0, 32'h0};
      tbl[1]  = '{0, 1'b0, 1'b1, 32'd1024,      32'hDEADBEEF,  4'd1,  1'b0, 5, 32'h0};
      tbl[2]  = '{0, 1'b1, 1'b0, 32'd1024,      32'h0,         4'd2,  1'b1, 5, 32'hDEADBEEF};
      tbl[3]  = '{0, 1'b0, 1'b1, 32'd1028,      32'h0000_0001, 4'd0,  1'b0, 5, 32'hDEADBEEF};
      tbl[4]  = '{0, 1'b1, 1'b0, 32'd1028,      32'h0,         4'd7,  1'b1, 5, 32'h0000_0001};
      tbl[5]  = '{0, 1'b0, 1'b1, 32'd1020,      32'hCAFEF00D,  4'd0,  1'b0, 5, 32'h0000_0001};
      tbl[6]  = '{0, 1'b1, 1'b0, 32'd1023,      32'h0,         4'd9,  1'b1, 5, 32'hCAFEF00D};
      tbl[7]  = '{0, 1'b1, 1'b1, 32'd1024,      32'h1111_2222, 4'd4,  1'b0, 5, 32'hCAFEF00D};
      tbl[8]  = '{0, 1'b1, 1'b0, 32'd1026,      32'h0,         4'd6,  1'b1, 5, 32'h1111_2222};
      tbl[9]  = '{0, 1'b0, 1'b0, 32'h0,         32'h0,         4'd15, 1'b0, 0, 32'h1111_2222};
      tbl[10] = '{1, 1'b1, 1'b0, 32'd1024,      32'h0,         4'd1,  1'b1, 9, 32'h0};
      tbl[11] = '{1, 1'b0, 1'b1, 32'd1100,      32'h55AA_1234, 4'd2,  1'b0, 9, 32'h0};
      tbl[12] = '{1, 1'b1, 1'b0, 32'd1100,      32'h0,         4'd3,  1'b1, 9, 32'h55AA_1234};
      tbl[13] = '{1, 1'b0, 1'b0, 32'h0000_0ABC, 32'h0,         4'd8,  1'b1, 0, 32'h55AA_1234};

      for (int s = 0; s < 2; s++) begin
         wb_in[s] = 1'b0; r_in[s] = 1'b0; w_in[s] = 1'b0;
         alu_in[s] = '0; val_in[s] = '0; dest_in[s] = '0;
         last_load[s] = 32'h0;
      end
      rst = 1'b0;
      #1 rst = 1'b1;
      #2;
      for (int s = 0; s < 2; s++) begin
         chk("rst_ready", {63'd0, rdy_o[s]}, 64'd1);
         chk("rst_mem_data", {32'd0, mdat_o[s]}, 64'd0);
         chk("rst_sram_addr", {46'd0, addr_o[s]}, 64'd0);
         chk("rst_dq_out", {48'd0, dqo[s]}, 64'd0);
         chk("rst_dq_oe", {63'd0, oe_o[s]}, 64'd0);
         chk("rst_we_n", {63'd0, wen_o[s]}, 64'd1);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 14; i++)
         do_op(tbl[i].sel, tbl[i].r, tbl[i].w, tbl[i].alu, tbl[i].val, tbl[i].dest, tbl[i].wb,
               tbl[i].lat, tbl[i].data);

      // Reset during the high half of a store: low half stays written, high half never lands.
      wb_in[0] = 1'b1; r_in[0] = 1'b0; w_in[0] = 1'b1;
      alu_in[0] = 32'd1600; val_in[0] = 32'h1234_5678; dest_in[0] = 4'd3;
      repeat (4) @(negedge clk);
      chk("hi_phase_we_n", {63'd0, wen_o[0]}, 64'd0);
      chk("hi_phase_addr", {46'd0, addr_o[0]}, 64'd289);
      rst = 1'b1;
      #1;
      chk("midrst_we_n", {63'd0, wen_o[0]}, 64'd1);
      chk("midrst_dq_oe", {63'd0, oe_o[0]}, 64'd0);
      chk("midrst_mem_data", {32'd0, mdat_o[0]}, 64'd0);
      chk("midrst_ready_req", {63'd0, rdy_o[0]}, 64'd0);
      w_in[0] = 1'b0;
      #1;
      chk("midrst_ready_idle", {63'd0, rdy_o[0]}, 64'd1);
      @(negedge clk);
      rst = 1'b0;
      chk("partial_lo", {48'd0, m0.mem[288]}, 64'h5678);
      chk("partial_hi", {48'd0, m0.mem[289]}, 64'h0);
      ref_mem[key(0, 17'd144)] = 32'h0000_5678;
      last_load[0] = 32'h0;
      last_load[1] = 32'h0;
      @(posedge clk);
      #1;

      do_op(0, 1'b1, 1'b0, 32'd1600, 32'h0, 4'd2, 1'b1, 5, 32'h0000_5678);

      // Randomised mix of ALU ops, loads, stores and read+write collisions against the word model.
      for (int i = 0; i < 60; i++) begin
         int          sel, kind;
         bit          r, w;
         logic [31:0] alu, expd;
         sel  = (i < 45) ? 0 : 1;
         kind = int'($urandom_range(0, 3));
         r    = (kind == 2) || (kind == 3);
         w    = (kind == 1) || (kind == 3);
         alu  = 32'd1024 + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
         expd = (r && !w) ? ref_read(sel, widx(alu)) : last_load[sel];
         do_op(sel, r, w, alu, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               (r || w) ? 2 * wcy(sel) + 3 : 0, expd);
      end

      chk("m0_write_without_oe", 64'(m0.bad_wr), 64'd0);
      chk("m1_write_without_oe", 64'(m1.bad_wr), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
